uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side front end for the `nibu` core's UART port. Samples the asynchronous serial line, deserialises 8-bit frames and buffers them in a show-ahead FIFO. The FIFO drives `nibu`'s `uart_empty`/`uart_in` inputs and is popped by its `uart_rdreq` output. Framing, parity and overrun conditions are reported as single-cycle pulses for debug LEDs.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); must be ≥ 4.
- `DEPTH_LOG2`, 4, log2 of FIFO depth (16 entries).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input, idle high.
- `uart_rdreq`  in  1  pop request from the core.
- `uart_empty`  out  1  FIFO holds no bytes.
- `uart_in`  out  8  head-of-FIFO byte (show-ahead).
- `uart_full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- `overrun`  out  1  pulse: a good byte was dropped because the FIFO was full.
- `frame_err`  out  1  pulse: stop bit sampled low.
- `parity_err`  out  1  pulse: parity mismatch (only with `UART_RX_PARITY_EN`).

## Operation
- **Input sync:** `rx` passes through a 2-FF synchroniser, reset to 1. All FSM decisions use the synchronised value `rxs`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, RECOVER. One bit-timer counts 0..CLKS_PER_BIT-1; one 3-bit bit index.
  - IDLE: when `rxs`=0, go to START and clear the timer.
  - START: when the timer reaches CLKS_PER_BIT/2-1 (integer divide), sample. If `rxs`=1 it was a glitch: go to IDLE. If `rxs`=0, go to DATA with timer=0 and index=0.
  - DATA: sample each time the timer reaches CLKS_PER_BIT-1, then reset the timer. Bits arrive LSB first into a shift register. After index 7, go to PARITY if enabled, otherwise STOP.
  - PARITY: sample one bit; even parity over data plus parity bit must be 0.
  - STOP: sample one bit.
    - `rxs`=1 and parity OK: write the byte, go to IDLE.
    - `rxs`=1 and parity bad: pulse `parity_err`, drop the byte, go to IDLE.
    - `rxs`=0: pulse `frame_err`, drop the byte, go to RECOVER.
  - RECOVER: wait for `rxs`=1, then go to IDLE. This prevents a break condition from being read as a stream of frames.
- **FIFO:** register array, write and read pointers of DEPTH_LOG2 bits, occupancy counter of DEPTH_LOG2+1 bits. Pointers wrap modulo depth.
  - Write is attempted on the STOP-accept cycle.
  - Write succeeds if not full, or if full and `uart_rdreq` is asserted in the same cycle. Otherwise pulse `overrun` and drop the byte.
  - Pop occurs on `uart_rdreq` & !`uart_empty`. `uart_rdreq` while empty is ignored; no state changes.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- **`uart_in`:** shows `mem[rd_ptr]` when not empty, and is forced to 8'h00 when empty.
- **Reset mid-frame:** the FSM returns to IDLE and the FIFO empties. The partial frame is lost with no error pulse.

## Timing
- Reset values:
  - `uart_empty`=1, `uart_full`=0, `uart_in`=8'h00.
  - `overrun`=`frame_err`=`parity_err`=0.
  - FSM in IDLE, synchroniser outputs 1.
- `uart_empty`, `uart_full` and the occupancy counter are registered. They update in the cycle after a push or pop.
- `uart_in` is valid in the same cycle `uart_empty` goes low. After a pop, the next byte (or 8'h00) appears in the following cycle.
- Latency: the `rx` falling edge reaches the FIFO write after 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles (8N1), plus CLKS_PER_BIT with parity. `uart_empty` falls one cycle later.
- All error pulses are exactly 1 cycle wide and coincide with the STOP (or overrun) decision cycle.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1; the PARITY state is used.
  - A mismatch pulses `parity_err` and drops the byte.
- `UART_RX_PARITY_EN` undefined:
  - Frame is 8N1; PARITY is never entered.
  - `parity_err` is tied to 0.

## Test plan
Bench uses CLKS_PER_BIT=8, DEPTH_LOG2=2, and a 20 ns clock.
1. **Reset:** hold `rst` 3 cycles with `rx`=1. Expect `uart_empty`=1, `uart_in`=00, all pulses 0, `uart_full`=0.
2. **Single byte:** send 8'hA5 (8N1). Expect `uart_empty`=0 with `uart_in`=A5 at 2+4+72+1 cycles after the start edge. Pulse `uart_rdreq` → `uart_empty`=1, `uart_in`=00 next cycle.
3. **Fill and overrun:** send 5 bytes 01..05 with no reads. Expect `uart_full`=1 after the 4th, an `overrun` pulse on the 5th, then reads return 01,02,03,04.
4. **Framing error:** send 8'h3C with stop=0 and hold `rx` low 40 cycles. Expect one `frame_err` pulse, FIFO still empty, no further frames. Then `rx`=1 and send 8'h11 → `uart_in`=11.
5. **Glitch and simultaneous access:** drive a 2-cycle low pulse on `rx` → no byte. With the FIFO full, assert `uart_rdreq` on the STOP cycle of byte 8'h77 → no `overrun`, and `uart_full` stays 1.
6. **Parity (`UART_RX_PARITY_EN`):** send 8'h03 with parity 0 → accepted. Send 8'h03 with parity 1 → `parity_err` pulse, byte dropped.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive front end for the nibu UART port: synchronises the serial line,
//   deserialises 8-bit frames (LSB first) and buffers them in a show-ahead FIFO
//   that feeds the core's uart_empty / uart_in inputs and is popped by
//   uart_rdreq. Framing, parity and overrun conditions produce 1-cycle pulses.
//
//   Build option: define UART_RX_PARITY_EN for 8E1 frames (even parity,
//   parity_err active); leave it undefined for 8N1 (parity_err tied to 0).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
//   DEPTH_LOG2    log2 of FIFO depth (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx          asynchronous serial input, idle high
//   uart_rdreq  pop request from the core (ignored while empty)
//   uart_empty  FIFO holds no bytes (registered)
//   uart_in     head-of-FIFO byte, 8'h00 while empty (registered)
//   uart_full   FIFO holds 2^DEPTH_LOG2 bytes (registered)
//   overrun     pulse: good byte dropped because the FIFO was full
//   frame_err   pulse: stop bit sampled low
//   parity_err  pulse: parity mismatch (parity build only)
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       uart_rdreq,
  output logic       uart_empty,
  output logic [7:0] uart_in,
  output logic       uart_full,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_RECOVER = 3'd5
  } state_e;

`ifdef UART_RX_PARITY_EN
  // Even parity over data plus parity bit: a set result means a mismatch.
  function automatic logic parity_bad(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  logic          sync1_q, rxs_q;
  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          frame_err_q;
  logic          bit_done_s, wr_s;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, parity_err_q;
`endif

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, full_q, overrun_q;
  logic [7:0]            head_q, head_d;
  logic                  push_s, pop_s;

  // Two-flop synchroniser for the asynchronous serial line, idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  assign bit_done_s = (timer_q == BIT_END);
  // The stop-accept cycle: this is when a FIFO write is attempted.
`ifdef UART_RX_PARITY_EN
  assign wr_s = (state_q == S_STOP) && bit_done_s && rxs_q && !par_bad_q;
`else
  assign wr_s = (state_q == S_STOP) && bit_done_s && rxs_q;
`endif

  // Receive FSM: bit timing, deserialisation and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= TW'(0);
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          timer_q <= TW'(0);
          if (!rxs_q) state_q <= S_START;
        end
        S_START: begin
          // Mid-start-bit check rejects short glitches on the line.
          if (timer_q == HALF_END) begin
            timer_q <= TW'(0);
            idx_q   <= 3'd0;
            state_q <= rxs_q ? S_IDLE : S_DATA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_DATA: begin
          if (bit_done_s) begin
            timer_q <= TW'(0);
            shift_q <= {rxs_q, shift_q[7:1]};
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (bit_done_s) begin
            timer_q   <= TW'(0);
            par_bad_q <= parity_bad(shift_q, rxs_q);
            state_q   <= S_STOP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
`else
          state_q <= S_IDLE;
`endif
        end
        S_STOP: begin
          if (bit_done_s) begin
            timer_q <= TW'(0);
            if (rxs_q) begin
              state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_bad_q;
`endif
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_RECOVER;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_RECOVER: begin
          // Wait out a break so a held-low line is not read as frames.
          if (rxs_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO next-state: occupancy, read pointer and the next head byte.
  always_comb begin
    pop_s  = uart_rdreq && !empty_q;
    // A full FIFO still accepts when a pop frees a slot in the same cycle.
    push_s = wr_s && (!full_q || uart_rdreq);
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    rd_ptr_d = pop_s ? (rd_ptr_q + DEPTH_LOG2'(1)) : rd_ptr_q;
    // The byte being written becomes the head when it lands in the slot
    // the read pointer will point at next.
    if (count_d == CW'(0)) begin
      head_d = 8'h00;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = shift_q;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage array (contents need no reset; head/empty gate visibility).
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= shift_q;
  end

  // FIFO pointers, flags, head register and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      head_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= (count_d == CW'(0));
      full_q    <= (count_d == CNT_FULL);
      head_q    <= head_d;
      overrun_q <= wr_s && full_q && !uart_rdreq;
    end
  end

  assign uart_empty = empty_q;
  assign uart_full  = full_q;
  assign uart_in    = head_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
